// File: rtl/ifu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifu_pkg : shared types for the instruction-fetch controller          |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package ifu_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } ifu_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        misalign;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage
`default_nettype wire

// File: rtl/ifu_fetch_ctrl_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifu_fifo : synchronous FIFO with flush and same-cycle push/pop       |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module ifu_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_wen;
  logic [PTR_W-1:0] w_widx;

  assign w_full  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign w_push = push_i & (~w_full | pop_i);
  assign w_pop  = pop_i & ~empty_o;

  // A flush restarts both pointers at zero, so a push in the flush cycle lands in slot 0
  assign w_wen  = flush_i ? push_i : w_push;
  assign w_widx = flush_i ? '0 : wr_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= push_i ? PTR_W'(1) : '0;
      count_q  <= push_i ? CNT_W'(1) : '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wen) mem_q[w_widx] <= push_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifu_fetch_ctrl : fetch PC owner, single-outstanding imem requester   |
// | and instruction buffer; optional IFU_MISALIGN_CHK_EN misalign trap.  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_vld,
  input  logic        redirect_taken,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ifu_vld,
  input  logic        ifu_rdy,
  output logic [63:0] ifu_pc,
  output logic [31:0] ifu_inst,
  output logic        ifu_misalign
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

  ifu_state_e   state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  gnt_addr_q;
  logic         halt_q, halt_d;

  logic         w_taken;
  logic [63:0]  w_redir_pc;
  logic         w_misalign_redir;
  logic         w_req_fire;
  logic         w_pop;
  logic         w_push;
  logic         w_empty;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_cnt_after;
  logic         w_credit;
  logic         w_credit_after;
  logic         w_pending_after;
  fetch_entry_t w_push_entry;
  fetch_entry_t w_head;

  assign w_taken    = redirect_vld & redirect_taken;
  assign w_req_fire = (state_q == REQ) & imem_gnt;

`ifdef IFU_MISALIGN_CHK_EN
  assign w_redir_pc       = redirect_pc;
  assign w_misalign_redir = w_taken & (redirect_pc[1:0] != 2'b00);
  assign ifu_misalign     = ifu_vld & w_head.misalign;
`else
  logic w_unused_misalign;
  assign w_redir_pc        = {redirect_pc[63:2], 2'b00};
  assign w_misalign_redir  = 1'b0;
  assign ifu_misalign      = 1'b0;
  assign w_unused_misalign = ^{redirect_pc[1:0], w_head.misalign};
`endif

  // Handshakes in a redirect cycle are dropped; the flush discards the head anyway
  assign w_pop  = ifu_vld & ifu_rdy & ~w_taken;
  assign w_push = ((state_q == WAIT) & imem_rvalid & ~w_taken) | w_misalign_redir;

  always_comb begin
    w_push_entry = '{pc: gnt_addr_q, inst: imem_rdata, misalign: 1'b0};
    if (w_misalign_redir) w_push_entry = '{pc: w_redir_pc, inst: 32'h0, misalign: 1'b1};
  end

  assign w_credit       = (w_count < CNT_W'(BUF_DEPTH));
  assign w_cnt_after    = w_count + CNT_W'(1) - CNT_W'(w_pop);
  assign w_credit_after = (w_cnt_after < CNT_W'(BUF_DEPTH));

  // A response is still owed after this cycle unless it arrives right now
  assign w_pending_after = (((state_q == WAIT) || (state_q == DROP)) && !imem_rvalid)
                         || w_req_fire;

  ifu_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (w_push),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .flush_i     (w_taken),
    .head_o      (w_head),
    .empty_o     (w_empty),
    .count_o     (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      gnt_addr_q <= RESET_PC;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      halt_q     <= halt_d;
      if (w_req_fire) gnt_addr_q <= pc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    halt_d  = halt_q;
    if (w_taken) begin
      pc_d   = w_redir_pc;
      halt_d = w_misalign_redir;
      if (w_pending_after)       state_d = DROP;
      else if (w_misalign_redir) state_d = IDLE;
      else                       state_d = REQ;
    end else begin
      if (w_req_fire) pc_d = pc_q + 64'd4;
      case (state_q)
        IDLE:    if (!halt_q && w_credit) state_d = REQ;
        REQ:     if (imem_gnt) state_d = WAIT;
        WAIT:    if (imem_rvalid) state_d = w_credit_after ? REQ : IDLE;
        DROP:    if (imem_rvalid) state_d = halt_q ? IDLE : REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    if (state_q == REQ) imem_req = 1'b1;
  end

  assign ifu_vld  = ~w_empty;
  assign ifu_pc   = ifu_vld ? w_head.pc   : 64'h0;
  assign ifu_inst = ifu_vld ? w_head.inst : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ifu_fetch_ctrl : scoreboard bench for ifu_fetch_ctrl              |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_vld = 1'b0;
  logic        redirect_taken = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        ifu_vld;
  logic        ifu_rdy = 1'b0;
  logic [63:0] ifu_pc;
  logic [31:0] ifu_inst;
  logic        ifu_misalign;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] addr_q[$];
  int          checks = 0;
  int          errors = 0;
  int          gnt_budget = 0;
  int          rlat = 1;
  int          stale_n = 0;
  int          gnt_total = 0;
  int          pend_cnt = 0;
  logic [63:0] pend_addr = 64'h0;

  always #5 clk = ~clk;

  ifu_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_vld   (redirect_vld),
    .redirect_taken (redirect_taken),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .ifu_vld        (ifu_vld),
    .ifu_rdy        (ifu_rdy),
    .ifu_pc         (ifu_pc),
    .ifu_inst       (ifu_inst),
    .ifu_misalign   (ifu_misalign)
  );

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic expect_fetch(input logic [63:0] a, input bit presented);
    addr_q.push_back(a);
    if (presented) exp_q.push_back('{pc: a, inst: inst_of(a), mis: 1'b0});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    gnt_budget = 0;
    ifu_rdy = 1'b0;
    redirect_vld = 1'b0;
    redirect_taken = 1'b0;
    rlat = 1;
    stale_n = 0;
    tick(2);
    chk("rst_imem_req", 64'(imem_req), 64'h0);
    chk("rst_imem_addr", imem_addr, 64'h8000_0000);
    chk("rst_ifu_vld", 64'(ifu_vld), 64'h0);
    chk("rst_ifu_pc", ifu_pc, 64'h0);
    chk("rst_ifu_inst", 64'(ifu_inst), 64'h0);
    chk("rst_ifu_misalign", 64'(ifu_misalign), 64'h0);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d outputs and %0d fetches outstanding, required 0",
               name, exp_q.size(), addr_q.size());
    end
    tick(3);
  endtask

  task automatic wait_gnt(input int target, input string name);
    int n = 0;
    while (gnt_total < target && n < 50) begin
      tick();
      n++;
    end
    if (gnt_total < target) begin
      checks++;
      errors++;
      $display("FAIL %s_wait_gnt: got %0d grants, required %0d", name, gnt_total, target);
    end
  endtask

  task automatic redirect(input logic taken, input logic [63:0] pc);
    redirect_vld = 1'b1;
    redirect_taken = taken;
    redirect_pc = pc;
  endtask

  // Instruction memory model: grants under a budget, answers rlat cycles later
  initial forever begin
    @(negedge clk);
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    if (rst) begin
      pend_cnt = 0;
    end else begin
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1;
          if (stale_n > 0) begin
            imem_rdata = 32'hDEAD_BEEF;
            stale_n--;
          end else begin
            imem_rdata = inst_of(pend_addr);
          end
        end
      end
      if (imem_req && gnt_budget > 0) begin
        imem_gnt = 1'b1;
        gnt_budget--;
        gnt_total++;
        pend_cnt = rlat;
        pend_addr = imem_addr;
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL imem_addr: unexpected grant at %h, required none", imem_addr);
        end else begin
          chk("imem_addr", imem_addr, addr_q.pop_front());
        end
      end
    end
  end

  // Output monitor: every accepted instruction is matched against the scoreboard
  initial forever begin
    @(negedge clk);
    #4;
    if (!rst && ifu_vld && ifu_rdy && !(redirect_vld && redirect_taken)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ifu_out: unexpected pc %h inst %h, required none", ifu_pc, ifu_inst);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ifu_pc", ifu_pc, e.pc);
        chk("ifu_inst", 64'(ifu_inst), 64'(e.inst));
        chk("ifu_misalign", 64'(ifu_misalign), 64'(e.mis));
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation still running, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int req_seen;

    // Sequential fetch, zero-wait memory
    do_reset();
    ifu_rdy = 1'b1;
    gnt_budget = 3;
    expect_fetch(64'h8000_0000, 1'b1);
    expect_fetch(64'h8000_0004, 1'b1);
    expect_fetch(64'h8000_0008, 1'b1);
    tick();
    chk("p1_first_req", 64'(imem_req), 64'h1);
    tick();
    chk("p1_vld_early", 64'(ifu_vld), 64'h0);
    tick();
    chk("p1_vld_latency", 64'(ifu_vld), 64'h1);
    chk("p1_first_pc", ifu_pc, 64'h8000_0000);
    drain("p1");

    // Back-pressure: credit stops fetch after BUF_DEPTH grants
    do_reset();
    base = gnt_total;
    gnt_budget = 5;
    for (int i = 0; i < 5; i++) expect_fetch(64'h8000_0000 + 64'(4 * i), 1'b1);
    tick(10);
    chk("p2_grants", 64'(gnt_total - base), 64'd2);
    chk("p2_req_low", 64'(imem_req), 64'h0);
    chk("p2_vld_held", 64'(ifu_vld), 64'h1);
    ifu_rdy = 1'b1;
    drain("p2");

    // Taken redirect while waiting: stale response goes through DROP
    do_reset();
    ifu_rdy = 1'b1;
    rlat = 3;
    stale_n = 1;
    base = gnt_total;
    gnt_budget = 1;
    expect_fetch(64'h8000_0000, 1'b0);
    wait_gnt(base + 1, "p3");
    tick();
    redirect(1'b1, 64'h8000_1000);
    expect_fetch(64'h8000_1000, 1'b1);
    gnt_budget = 1;
    tick();
    redirect_vld = 1'b0;
    chk("p3_vld_after_redirect", 64'(ifu_vld), 64'h0);
    chk("p3_req_in_drop", 64'(imem_req), 64'h0);
    drain("p3");

    // Redirect with rvalid same cycle, then redirect during grant and during DROP
    do_reset();
    ifu_rdy = 1'b1;
    stale_n = 2;
    base = gnt_total;
    gnt_budget = 1;
    expect_fetch(64'h8000_0000, 1'b0);
    wait_gnt(base + 1, "p4");
    tick();
    redirect(1'b1, 64'h8000_1800);
    expect_fetch(64'h8000_1800, 1'b0);
    gnt_budget = 1;
    rlat = 3;
    tick();
    chk("p4_second_grant", 64'(gnt_total - base), 64'd2);
    redirect(1'b1, 64'h8000_1C00);
    tick();
    redirect(1'b1, 64'h8000_2000);
    tick();
    redirect_vld = 1'b0;
    expect_fetch(64'h8000_2000, 1'b1);
    gnt_budget = 1;
    drain("p4");

    // Not-taken redirect has no effect
    do_reset();
    ifu_rdy = 1'b1;
    base = gnt_total;
    gnt_budget = 4;
    for (int i = 0; i < 4; i++) expect_fetch(64'h8000_0000 + 64'(4 * i), 1'b1);
    wait_gnt(base + 2, "p5");
    redirect(1'b0, 64'h9000_0000);
    tick();
    redirect_vld = 1'b0;
    drain("p5");

    // Flush of a full buffer, handshake in the redirect cycle ignored
    do_reset();
    gnt_budget = 2;
    expect_fetch(64'h8000_0000, 1'b0);
    expect_fetch(64'h8000_0004, 1'b0);
    tick(8);
    chk("p6_full", 64'(ifu_vld), 64'h1);
    redirect(1'b1, 64'h8000_3000);
    ifu_rdy = 1'b1;
    gnt_budget = 1;
    expect_fetch(64'h8000_3000, 1'b1);
    tick();
    redirect_vld = 1'b0;
    chk("p6_flushed", 64'(ifu_vld), 64'h0);
    chk("p6_req_next", 64'(imem_req), 64'h1);
    chk("p6_addr_next", imem_addr, 64'h8000_3000);
    tick();
    chk("p6_vld_n2", 64'(ifu_vld), 64'h0);
    tick();
    chk("p6_vld_n3", 64'(ifu_vld), 64'h1);
    chk("p6_pc_n3", ifu_pc, 64'h8000_3000);
    drain("p6");

    // Misaligned redirect target
    do_reset();
    tick(2);
`ifdef IFU_MISALIGN_CHK_EN
    redirect(1'b1, 64'h8000_1002);
    tick();
    redirect_vld = 1'b0;
    chk("p7_mis_vld", 64'(ifu_vld), 64'h1);
    chk("p7_mis_flag", 64'(ifu_misalign), 64'h1);
    chk("p7_mis_pc", ifu_pc, 64'h8000_1002);
    chk("p7_mis_inst", 64'(ifu_inst), 64'h0);
    exp_q.push_back('{pc: 64'h8000_1002, inst: 32'h0, mis: 1'b1});
    ifu_rdy = 1'b1;
    req_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (imem_req) req_seen++;
    end
    chk("p7_halt_req", 64'(req_seen), 64'h0);
    chk("p7_halt_vld", 64'(ifu_vld), 64'h0);
    redirect(1'b1, 64'h8000_4000);
    expect_fetch(64'h8000_4000, 1'b1);
    gnt_budget = 1;
    tick();
    redirect_vld = 1'b0;
    chk("p7_resume_addr", imem_addr, 64'h8000_4000);
`else
    redirect(1'b1, 64'h8000_1002);
    expect_fetch(64'h8000_1000, 1'b1);
    gnt_budget = 1;
    ifu_rdy = 1'b1;
    tick();
    redirect_vld = 1'b0;
    chk("p7_forced_align", imem_addr, 64'h8000_1000);
    req_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ifu_misalign) req_seen++;
    end
    chk("p7_misalign_low", 64'(req_seen), 64'h0);
`endif
    drain("p7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
